// File: rtl/if_stage.sv
// Instruction fetch: owns the fetch PC, drives a variable-latency imem via req/ready and
// buffers {instr, pc} in a DEPTH-entry prefetch FIFO feeding decode through valid/ready.
module if_stage #(
  parameter int              DWIDTH      = 16,
  parameter int              AWIDTH      = 16,
  parameter int              DEPTH       = 4,
  parameter logic [AWIDTH-1:0] RESET_PC  = '0,
  parameter int              PC_STEP     = 2,
  parameter logic [3:0]      HALT_OPCODE = 4'hF
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [AWIDTH-1:0]          imem_addr,
  input  logic                       imem_ready,
  input  logic [DWIDTH-1:0]          imem_data,
  input  logic                       redirect,
  input  logic [AWIDTH-1:0]          redirect_pc,
  output logic                       id_valid,
  output logic [DWIDTH-1:0]          id_instr,
  output logic [AWIDTH-1:0]          id_pc,
  input  logic                       id_ready,
  output logic                       halted,
  output logic [AWIDTH-1:0]          pc,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {RUN, SQUASH, HALT} state_t;

  state_t            state;
  logic [AWIDTH-1:0] squash_addr;
  logic [DWIDTH-1:0] instr_mem [DEPTH];
  logic [AWIDTH-1:0] pc_mem    [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              fifo_full;
  logic              enq;
  logic              deq;

  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_count = count;
  assign id_valid   = (count != '0);
  assign id_instr   = instr_mem[rd_ptr];
  assign id_pc      = pc_mem[rd_ptr];
  assign deq        = id_valid && id_ready;

  // In SQUASH the old request must stay on the bus until memory completes it.
  assign imem_req  = !rst && ((state == RUN && !fifo_full) || state == SQUASH);
  assign imem_addr = (state == SQUASH) ? squash_addr : pc;
  assign enq       = (state == RUN) && imem_req && imem_ready && !redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      squash_addr <= '0;
    end else if (redirect) begin
      pc <= redirect_pc;
      unique case (state)
        RUN: begin
          if (imem_req && !imem_ready) begin
            squash_addr <= pc;
            state       <= SQUASH;
          end
        end
        SQUASH:  state <= SQUASH;
        HALT:    state <= RUN;
        default: state <= RUN;
      endcase
    end else begin
      unique case (state)
        RUN: begin
          if (enq) begin
            pc <= pc + AWIDTH'(PC_STEP);
            if (imem_data[DWIDTH-1 -: 4] == HALT_OPCODE)
              state <= HALT;
          end
        end
        SQUASH: begin
          if (imem_ready)
            state <= RUN;
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else begin
      if (enq) begin
        instr_mem[wr_ptr] <= imem_data;
        pc_mem[wr_ptr]    <= pc;
      end
      // A dequeue in the redirect cycle still completes; the flush then empties the rest.
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq)
          wr_ptr <= wr_ptr + PW'(1);
        if (deq)
          rd_ptr <= rd_ptr + PW'(1);
        unique case ({enq, deq})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      halted <= 1'b0;
    else if (redirect)
      halted <= 1'b0;
    else if (deq && id_instr[DWIDTH-1 -: 4] == HALT_OPCODE)
      halted <= 1'b1;
  end

  enq_when_full: assert property (@(posedge clk) disable iff (rst) !(enq && fifo_full));

endmodule

// File: tb/tb_if_stage.sv
// Randomised and directed bench for if_stage against a queue-based fetch model.
module tb_if_stage;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ready = 1'b0;
  logic [DW-1:0] imem_data = '0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          id_valid;
  logic [DW-1:0] id_instr;
  logic [AW-1:0] id_pc;
  logic          id_ready = 1'b0;
  logic          halted;
  logic [AW-1:0] pc;
  logic [2:0]    fifo_count;

  always #5 clk = ~clk;

  if_stage #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .RESET_PC(16'h0000),
             .PC_STEP(2), .HALT_OPCODE(4'hF)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_ready(id_ready), .halted(halted), .pc(pc),
    .fifo_count(fifo_count)
  );

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } ent_t;

  // Model: fetched-but-undecoded instructions, fetch pointer, and whether an
  // abandoned request is still owed a response or fetching is stopped by HLT.
  ent_t        q[$];
  logic [15:0] m_pc;
  logic [15:0] m_dead_addr;
  bit          m_dead_pending;
  bit          m_stopped;
  bit          m_halted;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_pc           = 16'h0000;
    m_dead_addr    = 16'h0000;
    m_dead_pending = 0;
    m_stopped      = 0;
    m_halted       = 0;
  endfunction

  function automatic bit model_req();
    return m_dead_pending || (!m_stopped && q.size() < DEPTH);
  endfunction

  function automatic logic [15:0] model_addr();
    return m_dead_pending ? m_dead_addr : m_pc;
  endfunction

  task automatic compare_all();
    bit r;
    r = model_req();
    chk("imem_req", 32'(imem_req), 32'(r));
    if (r) chk("imem_addr", 32'(imem_addr), 32'(model_addr()));
    chk("id_valid", 32'(id_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("id_instr", 32'(id_instr), 32'(q[0].instr));
      chk("id_pc", 32'(id_pc), 32'(q[0].pc));
    end
    chk("halted", 32'(halted), 32'(m_halted));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
  endtask

  task automatic step(input bit rdy, input logic [15:0] dat, input bit rd,
                      input logic [15:0] rp, input bit idr);
    bit req;
    imem_ready  = rdy;
    imem_data   = dat;
    redirect    = rd;
    redirect_pc = rp;
    id_ready    = idr;
    req = model_req();
    @(posedge clk);
    if (idr && q.size() != 0) begin
      if (q[0].instr[15:12] == 4'hF) m_halted = 1;
      void'(q.pop_front());
    end
    if (rd) begin
      q.delete();
      m_halted = 0;
      if (m_stopped) m_stopped = 0;
      else if (!m_dead_pending && req && !rdy) begin
        m_dead_pending = 1;
        m_dead_addr    = m_pc;
      end
      m_pc = rp;
    end else if (m_dead_pending) begin
      if (rdy) m_dead_pending = 0;
    end else if (req && rdy) begin
      q.push_back('{dat, m_pc});
      m_pc = m_pc + 16'd2;
      if (dat[15:12] == 4'hF) m_stopped = 1;
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [15:0] d;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_instr", 32'(id_instr), 32'd0);
    chk("rst_idpc", 32'(id_pc), 32'd0);
    rst = 1'b0;
    #1;
    compare_all();
    chk("t1_addr0", 32'(imem_addr), 32'h0000);

    // Straight-line fetch with memory always ready.
    step(1, model_addr(), 0, 0, 1);
    chk("t1_addr1", 32'(imem_addr), 32'h0002);
    chk("t1_valid", 32'(id_valid), 32'd1);
    chk("t1_idpc", 32'(id_pc), 32'h0000);
    step(1, model_addr(), 0, 0, 1);
    chk("t1_addr2", 32'(imem_addr), 32'h0004);

    // Decode backpressure fills the FIFO.
    repeat (3) step(1, model_addr(), 0, 0, 0);
    chk("t2_full_count", 32'(fifo_count), 32'd4);
    chk("t2_full_req", 32'(imem_req), 32'd0);
    step(1, model_addr(), 0, 0, 1);
    chk("t2_req_back", 32'(imem_req), 32'd1);
    chk("t2_count3", 32'(fifo_count), 32'd3);
    chk("t2_head", 32'(id_pc), 32'h0004);

    // HLT stops fetch; redirect resumes.
    step(1, 16'h5555, 1, 16'h0006, 0);
    chk("t4_flush", 32'(fifo_count), 32'd0);
    step(1, 16'hF000, 0, 0, 0);
    chk("t4_noreq", 32'(imem_req), 32'd0);
    chk("t4_pc", 32'(pc), 32'h0008);
    chk("t4_instr", 32'(id_instr), 32'hF000);
    step(0, 0, 0, 0, 1);
    chk("t4_halted", 32'(halted), 32'd1);
    step(0, 0, 1, 16'h0020, 0);
    chk("t4_unhalt", 32'(halted), 32'd0);
    chk("t4_resume", 32'(imem_addr), 32'h0020);

    // Redirect while the memory stalls.
    step(0, 0, 1, 16'h0100, 0);
    chk("t3_hold", 32'(imem_addr), 32'h0020);
    chk("t3_pc", 32'(pc), 32'h0100);
    step(0, 0, 0, 0, 0);
    chk("t3_hold2", 32'(imem_addr), 32'h0020);
    step(1, 16'h1234, 0, 0, 1);
    chk("t3_newaddr", 32'(imem_addr), 32'h0100);
    chk("t3_novalid", 32'(id_valid), 32'd0);

    // Ready, dequeue and redirect together.
    step(1, 16'h1100, 0, 0, 0);
    chk("t5_count1", 32'(fifo_count), 32'd1);
    step(1, 16'h2222, 1, 16'h0040, 1);
    chk("t5_empty", 32'(fifo_count), 32'd0);
    chk("t5_addr", 32'(imem_addr), 32'h0040);

    // Asynchronous reset in the middle of a squash.
    step(0, 0, 1, 16'h0080, 0);
    chk("t6_sq_addr", 32'(imem_addr), 32'h0040);
    step(1, 16'h3333, 0, 0, 0);
    step(0, 0, 1, 16'h0090, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_req", 32'(imem_req), 32'd0);
    chk("t6_valid", 32'(id_valid), 32'd0);
    chk("t6_halted", 32'(halted), 32'd0);
    chk("t6_count", 32'(fifo_count), 32'd0);
    chk("t6_pc", 32'(pc), 32'h0000);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    compare_all();
    chk("t6_restart", 32'(imem_addr), 32'h0000);

    for (int i = 0; i < 2000; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 19) == 0) d[15:12] = 4'hF;
      else if (d[15:12] == 4'hF) d[15:12] = 4'hE;
      step(1'($urandom_range(0, 1)), d, ($urandom_range(0, 11) == 0),
           16'($urandom_range(0, 32767) * 2), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
